param_cache: RTL and testbench

Parametrised direct-mapped, write-back, write-allocate cache with multi-word lines. It sits between a CPU load/store port and a single-word memory port. It generalises our single-word instruction cache in three ways: configurable geometry, CPU writes with dirty tracking, and burst refill/writeback of whole lines.

---
 rtl/param_cache.sv | 236 +++++++++++++++++++++++
 tb/tb_param_cache.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_cache.sv
// param_cache: direct-mapped, write-back, write-allocate cache with multi-word
// lines between a CPU load/store port and a single-word memory port.
// Lines are refilled and written back as bursts of WPL single-word transfers.
// Optional feature: define CACHE_PERF_CNT_EN to add hit_cnt/miss_cnt ports.
//
//   state       | meaning
//   ------------+---------------------------------------------------------
//   S_IDLE      | waiting for a CPU request
//   S_COMPARE   | tag lookup; hit completes the request, miss starts a burst
//   S_WRITEBACK | writing the dirty victim line to memory, word 0 first
//   S_ALLOCATE  | reading the requested line from memory, word 0 first

module param_cache #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int INDEX_W = 4,
    parameter int OFFS_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] cpu_req_addr,
    input  logic              cpu_req_valid,
    input  logic              cpu_req_wr,
    input  logic [DATA_W-1:0] cpu_wr_data,
    output logic [DATA_W-1:0] cpu_req_data,
    output logic              cpu_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    output logic              mem_req_valid,
    output logic              mem_req_wr,
    input  logic [DATA_W-1:0] mem_req_data,
    input  logic              mem_req_ready
`ifdef CACHE_PERF_CNT_EN
    ,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
`endif
);

    localparam int B     = $clog2(DATA_W / 8);
    localparam int TAG_W = ADDR_W - B - OFFS_W - INDEX_W;
    localparam int LINES = 1 << INDEX_W;
    localparam int WPL   = 1 << OFFS_W;
    localparam int DM_W  = INDEX_W + OFFS_W;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_COMPARE   = 2'd1,
        S_WRITEBACK = 2'd2,
        S_ALLOCATE  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [DATA_W-1:0] data_mem [LINES*WPL];
    logic [LINES-1:0]  valid_bits;
    logic [LINES-1:0]  dirty_bits;

    logic [OFFS_W-1:0] word_cnt;
    logic [OFFS_W-1:0] word_next;
    logic [DATA_W-1:0] rd_hold;

    logic [OFFS_W-1:0]  req_word;
    logic [INDEX_W-1:0] req_index;
    logic [TAG_W-1:0]   req_tag;
    logic               hit;
    logic               victim_dirty;
    logic               xfer;
    logic               last_word;

    logic              dm_we;
    logic [DM_W-1:0]   dm_addr;
    logic [DATA_W-1:0] dm_wdata;

    // Byte-select bits never reach the array; memory addresses are word aligned.
    logic unused_addr_bits;
    assign unused_addr_bits = ^cpu_req_addr;

    assign req_word     = cpu_req_addr[B +: OFFS_W];
    assign req_index    = cpu_req_addr[B+OFFS_W +: INDEX_W];
    assign req_tag      = cpu_req_addr[ADDR_W-1 -: TAG_W];
    assign hit          = valid_bits[req_index] && (tag_mem[req_index] == req_tag);
    assign victim_dirty = valid_bits[req_index] && dirty_bits[req_index];
    assign xfer         = mem_req_valid && mem_req_ready;
    assign last_word    = &word_cnt;
    assign word_next    = word_cnt + OFFS_W'(1);

    function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0]   t,
                                                    input logic [INDEX_W-1:0] i,
                                                    input logic [OFFS_W-1:0]  w);
        return ADDR_W'({t, i, w}) << B;
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (cpu_req_valid) state_d = S_COMPARE;
            S_COMPARE: begin
                if (hit)               state_d = S_IDLE;
                else if (victim_dirty) state_d = S_WRITEBACK;
                else                   state_d = S_ALLOCATE;
            end
            S_WRITEBACK: if (xfer && last_word) state_d = S_ALLOCATE;
            S_ALLOCATE:  if (xfer && last_word) state_d = S_COMPARE;
            default:     state_d = S_IDLE;
        endcase
    end

    // CPU-side outputs and line-array write port
    always_comb begin
        cpu_req_ready = 1'b0;
        cpu_req_data  = rd_hold;
        dm_we         = 1'b0;
        dm_addr       = {req_index, req_word};
        dm_wdata      = cpu_wr_data;
        case (state_q)
            S_COMPARE: begin
                if (hit) begin
                    cpu_req_ready = 1'b1;
                    cpu_req_data  = data_mem[{req_index, req_word}];
                    dm_we         = cpu_req_wr;
                end
            end
            S_ALLOCATE: begin
                if (xfer) begin
                    dm_we    = 1'b1;
                    dm_addr  = {req_index, word_cnt};
                    dm_wdata = mem_req_data;
                end
            end
            default: ;
        endcase
    end

    // Line data and tags carry no reset; validity lives in valid_bits
    always_ff @(posedge clk) begin
        if (!rst && dm_we)
            data_mem[dm_addr] <= dm_wdata;
        if (!rst && state_q == S_ALLOCATE && xfer && last_word)
            tag_mem[req_index] <= req_tag;
    end

    // Line status, registered memory request and load-data hold register
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_bits    <= '0;
            dirty_bits    <= '0;
            word_cnt      <= '0;
            rd_hold       <= '0;
            mem_req_valid <= 1'b0;
            mem_req_wr    <= 1'b0;
            mem_req_addr  <= '0;
            mem_wr_data   <= '0;
        end else begin
            case (state_q)
                S_COMPARE: begin
                    if (hit) begin
                        rd_hold <= data_mem[{req_index, req_word}];
                        if (cpu_req_wr) dirty_bits[req_index] <= 1'b1;
                    end else begin
                        word_cnt      <= '0;
                        mem_req_valid <= 1'b1;
                        if (victim_dirty) begin
                            mem_req_wr   <= 1'b1;
                            mem_req_addr <= line_addr(tag_mem[req_index], req_index, '0);
                            mem_wr_data  <= data_mem[{req_index, OFFS_W'(0)}];
                        end else begin
                            mem_req_wr   <= 1'b0;
                            mem_req_addr <= line_addr(req_tag, req_index, '0);
                        end
                    end
                end
                S_WRITEBACK: begin
                    if (xfer) begin
                        if (last_word) begin
                            word_cnt     <= '0;
                            mem_req_wr   <= 1'b0;
                            mem_req_addr <= line_addr(req_tag, req_index, '0);
                        end else begin
                            word_cnt     <= word_next;
                            mem_req_addr <= line_addr(tag_mem[req_index], req_index, word_next);
                            mem_wr_data  <= data_mem[{req_index, word_next}];
                        end
                    end
                end
                S_ALLOCATE: begin
                    if (xfer) begin
                        if (last_word) begin
                            word_cnt              <= '0;
                            mem_req_valid         <= 1'b0;
                            valid_bits[req_index] <= 1'b1;
                            dirty_bits[req_index] <= 1'b0;
                        end else begin
                            word_cnt     <= word_next;
                            mem_req_addr <= line_addr(req_tag, req_index, word_next);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef CACHE_PERF_CNT_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;
    logic        from_alloc;

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;

    // Hit/miss counters; the hit that closes a refill is not a real hit
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            from_alloc <= 1'b0;
        end else begin
            from_alloc <= (state_q == S_ALLOCATE) && xfer && last_word;
            if (state_q == S_COMPARE && !hit)
                miss_cnt_q <= miss_cnt_q + 32'd1;
            if (state_q == S_COMPARE && hit && !from_alloc)
                hit_cnt_q <= hit_cnt_q + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_param_cache.sv
// Scoreboard bench for param_cache: expected CPU responses and memory
// transactions are queued by the stimulus, and a negedge monitor pops and
// compares them whenever the DUT completes a handshake.
module tb_param_cache;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] cpu_req_addr = '0;
    logic        cpu_req_valid = 1'b0;
    logic        cpu_req_wr = 1'b0;
    logic [31:0] cpu_wr_data = '0;
    logic [31:0] cpu_req_data;
    logic        cpu_req_ready;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_wr_data;
    logic        mem_req_valid;
    logic        mem_req_wr;
    logic [31:0] mem_req_data = '0;
    logic        mem_req_ready = 1'b0;
`ifdef CACHE_PERF_CNT_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    param_cache dut (
        .clk           (clk),
        .rst           (rst),
        .cpu_req_addr  (cpu_req_addr),
        .cpu_req_valid (cpu_req_valid),
        .cpu_req_wr    (cpu_req_wr),
        .cpu_wr_data   (cpu_wr_data),
        .cpu_req_data  (cpu_req_data),
        .cpu_req_ready (cpu_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_wr_data   (mem_wr_data),
        .mem_req_valid (mem_req_valid),
        .mem_req_wr    (mem_req_wr),
        .mem_req_data  (mem_req_data),
        .mem_req_ready (mem_req_ready)
`ifdef CACHE_PERF_CNT_EN
        ,
        .hit_cnt       (hit_cnt),
        .miss_cnt      (miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {logic [31:0] addr; logic wr; logic [31:0] data;} mem_exp_t;
    typedef struct {logic is_load; logic [31:0] data;} cpu_exp_t;

    mem_exp_t mem_q[$];
    cpu_exp_t cpu_q[$];
    logic [31:0] tbmem [logic [31:0]];

    int errors = 0;
    int checks = 0;
    int stall_cycles = 0;

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push_mem(input logic [31:0] addr, input logic wr, input logic [31:0] data);
        mem_exp_t e;
        e.addr = addr; e.wr = wr; e.data = data;
        mem_q.push_back(e);
    endtask

    task automatic push_reads(input logic [31:0] base);
        for (int i = 0; i < 4; i++) push_mem(base + 32'(4 * i), 1'b0, 32'h0);
    endtask

    // Issue one CPU request, wait (bounded) for ready and check the latency.
    task automatic cpu_op(input string name, input logic [31:0] addr, input logic wr,
                          input logic [31:0] wdata, input logic [31:0] exp, input int exp_lat);
        cpu_exp_t e;
        int n;
        logic done;
        e.is_load = !wr; e.data = exp;
        cpu_q.push_back(e);
        @(posedge clk); #1;
        cpu_req_addr = addr; cpu_req_wr = wr; cpu_wr_data = wdata; cpu_req_valid = 1'b1;
        n = 0; done = 1'b0;
        while (!done && n < 300) begin
            @(negedge clk);
            n++;
            if (cpu_req_ready) done = 1'b1;
        end
        checks++;
        if (!done || n != exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d cycles (done=%0b), expected %0d", name, n, done, exp_lat);
        end
        @(posedge clk); #1;
        cpu_req_valid = 1'b0;
    endtask

    // Memory responder: ready after stall_cycles wait cycles per word.
    initial begin
        int wait_cnt;
        wait_cnt = 0;
        forever begin
            @(posedge clk); #1;
            if (mem_req_valid && !rst) begin
                if (wait_cnt < stall_cycles) begin
                    mem_req_ready = 1'b0;
                    wait_cnt++;
                end else begin
                    mem_req_ready = 1'b1;
                    wait_cnt = 0;
                    if (mem_req_wr) tbmem[mem_req_addr] = mem_wr_data;
                    else mem_req_data = tbmem.exists(mem_req_addr) ? tbmem[mem_req_addr]
                                                                   : (mem_req_addr ^ 32'h5A5A_0000);
                end
            end else begin
                mem_req_ready = 1'b0;
                wait_cnt = 0;
            end
        end
    end

    // Monitor: pops scoreboard entries on completed handshakes.
    logic        prev_stall = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [31:0] prev_wdata = '0;
    logic        prev_wr = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (cpu_req_ready) begin
                checks++;
                if (cpu_q.size() == 0) begin
                    errors++;
                    $display("FAIL cpu_unexpected_ready: got ready at addr %h, expected none", cpu_req_addr);
                end else begin
                    cpu_exp_t e;
                    e = cpu_q.pop_front();
                    if (e.is_load && cpu_req_data !== e.data) begin
                        errors++;
                        $display("FAIL cpu_load_data @%h: got %h, expected %h", cpu_req_addr, cpu_req_data, e.data);
                    end
                end
            end
            if (prev_stall) begin
                checks++;
                if (!mem_req_valid || mem_req_addr !== prev_addr || mem_req_wr !== prev_wr ||
                    mem_wr_data !== prev_wdata) begin
                    errors++;
                    $display("FAIL mem_stall_hold: got v=%0b a=%h wr=%0b d=%h, expected v=1 a=%h wr=%0b d=%h",
                             mem_req_valid, mem_req_addr, mem_req_wr, mem_wr_data, prev_addr, prev_wr, prev_wdata);
                end
            end
            if (mem_req_valid && mem_req_ready) begin
                checks++;
                if (mem_q.size() == 0) begin
                    errors++;
                    $display("FAIL mem_unexpected_xfer: got a=%h wr=%0b, expected none", mem_req_addr, mem_req_wr);
                end else begin
                    mem_exp_t e;
                    e = mem_q.pop_front();
                    if (mem_req_addr !== e.addr || mem_req_wr !== e.wr || (e.wr && mem_wr_data !== e.data)) begin
                        errors++;
                        $display("FAIL mem_xfer: got a=%h wr=%0b d=%h, expected a=%h wr=%0b d=%h",
                                 mem_req_addr, mem_req_wr, mem_wr_data, e.addr, e.wr, e.data);
                    end
                end
            end
            prev_stall = mem_req_valid && !mem_req_ready;
            prev_addr  = mem_req_addr;
            prev_wr    = mem_req_wr;
            prev_wdata = mem_wr_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        tbmem[32'h100] = 32'hA0; tbmem[32'h104] = 32'hA1;
        tbmem[32'h108] = 32'hA2; tbmem[32'h10C] = 32'hA3;
        tbmem[32'h200] = 32'hB0; tbmem[32'h204] = 32'hB1;
        tbmem[32'h208] = 32'hB2; tbmem[32'h20C] = 32'hB3;
        tbmem[32'h410] = 32'hC0; tbmem[32'h414] = 32'hC1;
        tbmem[32'h418] = 32'hC2; tbmem[32'h41C] = 32'hC3;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_val("rst_cpu_ready", 32'(cpu_req_ready), 32'h0);
        check_val("rst_cpu_data", cpu_req_data, 32'h0);
        check_val("rst_mem_valid", 32'(mem_req_valid), 32'h0);
        check_val("rst_mem_addr", mem_req_addr, 32'h0);

        // Cold load: clean miss, burst refill of 0x100..0x10C
        push_reads(32'h100);
        cpu_op("cold_load_104", 32'h104, 1'b0, 32'h0, 32'hA1, 7);
`ifdef CACHE_PERF_CNT_EN
        check_val("miss_cnt_1", miss_cnt, 32'd1);
        check_val("hit_cnt_0", hit_cnt, 32'd0);
`endif
        // Load hit in the same line
        cpu_op("hit_load_10c", 32'h10C, 1'b0, 32'h0, 32'hA3, 2);
`ifdef CACHE_PERF_CNT_EN
        check_val("hit_cnt_1", hit_cnt, 32'd1);
`endif
        // Store hit marks the line dirty
        cpu_op("store_hit_104", 32'h104, 1'b1, 32'hDEAD_BEEF, 32'h0, 2);

        // Conflicting load: writeback of the dirty line, then refill
        push_mem(32'h100, 1'b1, 32'hA0);
        push_mem(32'h104, 1'b1, 32'hDEAD_BEEF);
        push_mem(32'h108, 1'b1, 32'hA2);
        push_mem(32'h10C, 1'b1, 32'hA3);
        push_reads(32'h200);
        cpu_op("dirty_miss_204", 32'h204, 1'b0, 32'h0, 32'hB1, 11);

        // Memory stalls of 5 cycles per word on a different index
        stall_cycles = 5;
        push_reads(32'h410);
        cpu_op("stall_load_418", 32'h418, 1'b0, 32'h0, 32'hC2, 27);
        stall_cycles = 0;

        // Store miss: allocate, then the store lands in the refilled line
        push_reads(32'h020);
        cpu_op("store_miss_028", 32'h028, 1'b1, 32'h1234_5678, 32'h0, 7);
        cpu_op("load_after_store_028", 32'h028, 1'b0, 32'h0, 32'h1234_5678, 2);

        // Reset during the second ALLOCATE read
        push_mem(32'h300, 1'b0, 32'h0);
        push_mem(32'h304, 1'b0, 32'h0);
        @(posedge clk); #1;
        cpu_req_addr = 32'h304; cpu_req_wr = 1'b0; cpu_req_valid = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        rst = 1'b1;
        cpu_req_valid = 1'b0;
        @(negedge clk);
        check_val("rst_mid_mem_valid", 32'(mem_req_valid), 32'h0);
        check_val("rst_mid_state", 32'(dut.state_q), 32'h0);
        check_val("rst_mid_cpu_ready", 32'(cpu_req_ready), 32'h0);
        @(posedge clk); #1 rst = 1'b0;

        // Reload after reset misses again and sees the written-back word
        push_reads(32'h100);
        cpu_op("reload_104", 32'h104, 1'b0, 32'h0, 32'hDEAD_BEEF, 7);

`ifdef CACHE_PERF_CNT_EN
        force dut.hit_cnt_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.hit_cnt_q;
        cpu_op("wrap_hit_108", 32'h108, 1'b0, 32'h0, 32'hA2, 2);
        check_val("hit_cnt_wrap", hit_cnt, 32'h0);
`endif

        repeat (5) @(posedge clk);
        check_val("cpu_q_empty", 32'(cpu_q.size()), 32'h0);
        check_val("mem_q_empty", 32'(mem_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
